dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesting thread lanes.
REQ-002 Parameter AW, default 16, data-memory address width.
REQ-003 Parameter DW, default 16, data-memory word width.
REQ-004 Parameter RD_LAT, default 1, data-memory read latency in cycles (1..4).
REQ-005 clk  in  1  single clock; all state SHALL update on the rising edge.
REQ-006 rst  in  1  synchronous reset, active-high.
REQ-007 req  in  NREQ  per-lane access request, held until that lane's ack.
REQ-008 we  in  NREQ  per-lane write enable: 1 = write, 0 = read.
REQ-009 addr  in  NREQ*AW  packed per-lane addresses; lane i at bits [i*AW +: AW].
REQ-010 wdata  in  NREQ*DW  packed per-lane write data; lane i at bits [i*DW +: DW].
REQ-011 ack  out  NREQ  one-hot, one-cycle completion pulse for the granted lane.
REQ-012 rdata  out  DW  read data, valid in the ack cycle of a read.
REQ-013 busy  out  1  high whenever state is not IDLE.
REQ-014 mem_wren  out  1  data-memory write enable.
REQ-015 mem_addr  out  AW  data-memory address.
REQ-016 mem_din  out  DW  data-memory write data.
REQ-017 mem_q  in  DW  data-memory read data, valid RD_LAT cycles after the address is presented.

Function
REQ-018 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, ACK.
REQ-019 IDLE: if any req bit is high, the block SHALL grant the first requesting lane found searching upward from rr_ptr with wrap, latch that lane's we/addr/wdata, and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-020 ISSUE (exactly 1 cycle): mem_addr = latched addr, mem_din = latched wdata, mem_wren = latched we; next state SHALL be ACK for a write and WAIT for a read.
REQ-021 WAIT: the block SHALL count RD_LAT cycles from the ISSUE cycle, capture mem_q into rdata on the last one, then go to ACK.
REQ-022 ACK (exactly 1 cycle): ack[granted] = 1, rr_ptr = (granted+1) mod NREQ, next state IDLE.
REQ-023 Latency from req sampled in IDLE (cycle 0) SHALL be ack in cycle 2 for a write and cycle 2+RD_LAT for a read.
REQ-024 mem_wren SHALL be high only in ISSUE of a write, for exactly one cycle per write.
REQ-025 Outside ISSUE, mem_addr and mem_din SHALL hold their last driven values.
REQ-026 rdata SHALL hold its value until the next read capture; write acks SHALL leave rdata unchanged.
REQ-027 Latched request fields SHALL be used for the whole transaction; changes on req/we/addr/wdata after grant SHALL have no effect, and a req drop after grant SHALL still complete with an ack.
REQ-028 A requester SHALL drop req on the edge at which it samples ack; a req still high in the IDLE cycle after ack SHALL be treated as a new request.
REQ-029 Round-robin fairness: with all lanes continuously requesting, the grant order SHALL be 0,1,2,...,NREQ-1,0,... with no lane granted twice before every other requesting lane has been granted once.
REQ-030 Only one transaction SHALL be outstanding at any time; req bits for lanes other than the granted one SHALL be ignored until IDLE.

Reset
REQ-031 While rst is high at an edge: state = IDLE, rr_ptr = 0, ack = 0, rdata = 0, busy = 0, mem_wren = 0, mem_addr = 0, mem_din = 0.
REQ-032 Reset in any state SHALL abort the transaction with no ack, and mem_wren SHALL be 0 from the first cycle after the reset edge.

Verification
REQ-033 Lane 2 writes addr 0x0005, data 0xBEEF, with RD_LAT=1 -> mem_wren high only in cycle 1 with mem_addr=0x0005 and mem_din=0xBEEF; ack=4'b0100 in cycle 2; busy high in cycles 1-2.
REQ-034 Lane 0 reads addr 0x0005 with memory returning 0xBEEF -> mem_wren stays 0; ack=4'b0001 in cycle 3; rdata=0xBEEF in cycle 3.
REQ-035 req=4'b1111 held continuously with reads -> acks in lane order 0,1,2,3,0, one every 4 cycles; no lane is starved.
REQ-036 rr_ptr=3 and req=4'b1001 -> lane 3 is granted first, then lane 0.
REQ-037 rst asserted during WAIT of a lane 1 read -> no ack; all outputs 0 in the next cycle; a following lane 1 request is granted normally.
REQ-038 Lane 1 changes addr from 0x0010 to 0x0020 the cycle after grant -> mem_addr=0x0010 in ISSUE.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter granting one of NREQ thread lanes a single data-memory access at a time.
// Four-state transaction sequencer: IDLE -> ISSUE -> (WAIT ->) ACK -> IDLE.
module dmem_arbiter #(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned AW     = 16,
  parameter int unsigned DW     = 16,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      we,
  input  logic [NREQ*AW-1:0]   addr,
  input  logic [NREQ*DW-1:0]   wdata,
  output logic [NREQ-1:0]      ack,
  output logic [DW-1:0]        rdata,
  output logic                 busy,
  output logic                 mem_wren,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_din,
  input  logic [DW-1:0]        mem_q
);

  localparam int unsigned LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    ACK
  } state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [LW-1:0]   lane_q, lane_d;
  logic            we_q, we_d;
  logic [CW-1:0]   lat_cnt_q, lat_cnt_d;
  logic            mem_wren_q, mem_wren_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_din_q, mem_din_d;
  logic [DW-1:0]   rdata_q, rdata_d;

  logic            found;
  logic [LW-1:0]   pick;
  int unsigned     idx;
  int unsigned     sel;

  // First requesting lane at or above rr_ptr, wrapping around.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (32'(rr_ptr_q) + i) % NREQ;
      if (!found && req[idx[LW-1:0]]) begin
        found = 1'b1;
        pick  = idx[LW-1:0];
      end
    end
  end

  // Memory-facing outputs are loaded at grant so they present during ISSUE and then hold.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    lane_d     = lane_q;
    we_d       = we_q;
    lat_cnt_d  = lat_cnt_q;
    mem_wren_d = 1'b0;
    mem_addr_d = mem_addr_q;
    mem_din_d  = mem_din_q;
    rdata_d    = rdata_q;
    sel        = 32'(pick);

    unique case (state_q)
      IDLE: begin
        if (found) begin
          lane_d     = pick;
          we_d       = we[pick];
          mem_wren_d = we[pick];
          mem_addr_d = addr[sel*AW +: AW];
          mem_din_d  = wdata[sel*DW +: DW];
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        lat_cnt_d = CW'(1);
        state_d   = we_q ? ACK : WAIT;
      end
      WAIT: begin
        if (lat_cnt_q == CW'(RD_LAT)) begin
          rdata_d = mem_q;
          state_d = ACK;
        end else begin
          lat_cnt_d = lat_cnt_q + 1'b1;
        end
      end
      ACK: begin
        rr_ptr_d = (lane_q == LW'(NREQ - 1)) ? '0 : lane_q + 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      lane_q     <= '0;
      we_q       <= 1'b0;
      lat_cnt_q  <= '0;
      mem_wren_q <= 1'b0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lane_q     <= lane_d;
      we_q       <= we_d;
      lat_cnt_q  <= lat_cnt_d;
      mem_wren_q <= mem_wren_d;
      mem_addr_q <= mem_addr_d;
      mem_din_q  <= mem_din_d;
      rdata_q    <= rdata_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == ACK) begin
      ack[lane_q] = 1'b1;
    end
  end

  assign busy     = (state_q != IDLE);
  assign mem_wren = mem_wren_q;
  assign mem_addr = mem_addr_q;
  assign mem_din  = mem_din_q;
  assign rdata    = rdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: a transaction-level model predicts every output each cycle,
// a synchronous RAM with RD_LAT pipeline stands in for the data memory.
module tb_dmem_arbiter;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned AW     = 16;
  localparam int unsigned DW     = 16;
  localparam int unsigned RD_LAT = 1;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [NREQ-1:0]     we;
  logic [NREQ*AW-1:0]  addr;
  logic [NREQ*DW-1:0]  wdata;
  logic [NREQ-1:0]     ack;
  logic [DW-1:0]       rdata;
  logic                busy;
  logic                mem_wren;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_din;
  logic [DW-1:0]       mem_q;

  dmem_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .ack(ack), .rdata(rdata), .busy(busy), .mem_wren(mem_wren),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] init_val(int i);
    return DW'(i * 37 + 3);
  endfunction

  // Data memory: write on edge, read data RD_LAT cycles after the address is presented.
  logic [DW-1:0] ram [0:255];
  logic [DW-1:0] rd_pipe [0:RD_LAT-1];
  logic          ram_clear;

  always @(posedge clk) begin
    if (ram_clear) begin
      for (int i = 0; i < 256; i++) ram[i] <= init_val(i);
    end else if (mem_wren) begin
      ram[mem_addr[7:0]] <= mem_din;
    end
    rd_pipe[0] <= ram[mem_addr[7:0]];
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_q = rd_pipe[RD_LAT-1];

  // Transaction model: k counts cycles since grant (ISSUE is k=1), ack at k=len.
  logic [DW-1:0] shadow [0:255];
  bit            m_active;
  int            m_k, m_len, m_lane, m_rr;
  bit            m_we;
  logic [AW-1:0] m_addr, m_last_addr;
  logic [DW-1:0] m_last_din, m_rdata;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [NREQ-1:0] m_ack();
    logic [NREQ-1:0] a;
    a = '0;
    if (m_active && m_k == m_len) a[m_lane] = 1'b1;
    return a;
  endfunction

  task automatic model_edge();
    int l;
    if (rst) begin
      m_active    = 1'b0;
      m_rr        = 0;
      m_rdata     = '0;
      m_last_addr = '0;
      m_last_din  = '0;
    end else if (m_active) begin
      if (m_k == m_len) begin
        m_active = 1'b0;
        m_rr     = (m_lane + 1) % NREQ;
      end else begin
        m_k++;
        if (m_k == m_len && !m_we) m_rdata = shadow[m_addr[7:0]];
      end
    end else if (req != '0) begin
      for (int i = 0; i < NREQ; i++) begin
        l = (m_rr + i) % NREQ;
        if (req[l]) begin
          m_lane = l;
          break;
        end
      end
      m_active    = 1'b1;
      m_k         = 1;
      m_we        = we[m_lane];
      m_addr      = addr[m_lane*AW +: AW];
      m_len       = m_we ? 2 : 2 + RD_LAT;
      m_last_addr = m_addr;
      m_last_din  = wdata[m_lane*DW +: DW];
      if (m_we) shadow[m_addr[7:0]] = m_last_din;
    end
  endtask

  task automatic compare();
    chk("ack", 32'(ack), 32'(m_ack()));
    chk("busy", 32'(busy), 32'(m_active));
    chk("mem_wren", 32'(mem_wren), 32'(m_active && m_we && m_k == 1));
    chk("mem_addr", 32'(mem_addr), 32'(m_last_addr));
    chk("mem_din", 32'(mem_din), 32'(m_last_din));
    chk("rdata", 32'(rdata), 32'(m_rdata));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic set_lane(int l, bit w, logic [AW-1:0] a, logic [DW-1:0] d);
    req[l]             = 1'b1;
    we[l]              = w;
    addr[l*AW +: AW]   = a;
    wdata[l*DW +: DW]  = d;
  endtask

  initial begin
    logic [NREQ-1:0] pend_ack;
    rst = 1'b1; req = '0; we = '0; addr = '0; wdata = '0; ram_clear = 1'b1;
    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
    m_active = 1'b0; m_k = 0; m_len = 0; m_lane = 0; m_rr = 0; m_we = 1'b0;
    m_addr = '0; m_last_addr = '0; m_last_din = '0; m_rdata = '0;

    cycle();
    cycle();
    chk("reset_busy", 32'(busy), 0);
    chk("reset_ack", 32'(ack), 0);
    chk("reset_wren", 32'(mem_wren), 0);
    chk("reset_addr", 32'(mem_addr), 0);
    chk("reset_rdata", 32'(rdata), 0);
    rst = 1'b0; ram_clear = 1'b0;

    // Lane 2 write
    set_lane(2, 1'b1, 16'h0005, 16'hBEEF);
    cycle();
    chk("wr_c1_wren", 32'(mem_wren), 1);
    chk("wr_c1_addr", 32'(mem_addr), 32'h0005);
    chk("wr_c1_din", 32'(mem_din), 32'hBEEF);
    chk("wr_c1_busy", 32'(busy), 1);
    cycle();
    chk("wr_c2_ack", 32'(ack), 32'b0100);
    chk("wr_c2_busy", 32'(busy), 1);
    chk("wr_c2_wren", 32'(mem_wren), 0);
    req[2] = 1'b0;
    cycle();
    chk("wr_c3_busy", 32'(busy), 0);

    // rr_ptr now 3: lanes 3 and 0 request, lane 3 first
    set_lane(3, 1'b1, 16'h0030, 16'h1111);
    set_lane(0, 1'b1, 16'h0031, 16'h2222);
    cycle();
    cycle();
    chk("rr_first_ack", 32'(ack), 32'b1000);
    req[3] = 1'b0;
    cycle();
    cycle();
    cycle();
    chk("rr_second_ack", 32'(ack), 32'b0001);
    req[0] = 1'b0;
    cycle();

    // Lane 0 read of the word written above
    set_lane(0, 1'b0, 16'h0005, 16'h0000);
    cycle();
    chk("rd_c1_wren", 32'(mem_wren), 0);
    cycle();
    chk("rd_c2_ack", 32'(ack), 0);
    cycle();
    chk("rd_c3_ack", 32'(ack), 32'b0001);
    chk("rd_c3_rdata", 32'(rdata), 32'hBEEF);
    req[0] = 1'b0;
    cycle();

    // Lane 1 address changes after grant
    set_lane(1, 1'b0, 16'h0010, 16'h0000);
    cycle();
    chk("latch_addr_issue", 32'(mem_addr), 32'h0010);
    addr[1*AW +: AW] = 16'h0020;
    cycle();
    cycle();
    chk("latch_ack", 32'(ack), 32'b0010);
    chk("latch_rdata", 32'(rdata), 32'(init_val(16)));
    req[1] = 1'b0;
    cycle();

    // Reset during WAIT of a lane 1 read
    set_lane(1, 1'b0, 16'h0006, 16'h0000);
    cycle();
    cycle();
    rst = 1'b1;
    cycle();
    chk("rstw_ack", 32'(ack), 0);
    chk("rstw_busy", 32'(busy), 0);
    chk("rstw_wren", 32'(mem_wren), 0);
    chk("rstw_addr", 32'(mem_addr), 0);
    chk("rstw_din", 32'(mem_din), 0);
    chk("rstw_rdata", 32'(rdata), 0);
    rst = 1'b0;
    cycle();
    chk("rstw_regrant_addr", 32'(mem_addr), 32'h0006);
    cycle();
    cycle();
    chk("rstw_regrant_ack", 32'(ack), 32'b0010);
    req[1] = 1'b0;
    cycle();

    // All lanes requesting reads continuously from rr_ptr 0
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    for (int l = 0; l < NREQ; l++) set_lane(l, 1'b0, AW'(l), '0);
    for (int c = 1; c <= 20; c++) begin
      cycle();
      if (c % 4 == 3) chk("fair_ack", 32'(ack), 32'(1 << ((c / 4) % 4)));
      else            chk("fair_noack", 32'(ack), 0);
    end
    req = '0;
    cycle();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      pend_ack = m_ack();
      rst = ($urandom_range(0, 199) == 0);
      for (int l = 0; l < NREQ; l++) begin
        if (pend_ack[l] && $urandom_range(0, 7) != 0) begin
          req[l] = 1'b0;
        end else if (!req[l]) begin
          if ($urandom_range(0, 3) == 0)
            set_lane(l, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
        end else if ($urandom_range(0, 31) == 0) begin
          req[l] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          we[l]             = 1'($urandom_range(0, 1));
          addr[l*AW +: AW]  = AW'($urandom_range(0, 15));
          wdata[l*DW +: DW] = DW'($urandom);
        end
      end
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
